tdm_voice_scheduler: RTL
========================

Name: tdm_voice_scheduler

Overview:
- Time-division scheduler that feeds the sample pipeline.
- Each dsp_clk slot it emits one voice's channel index, enable flag and fix15 sample, in round-robin order 0..NUM_VOICES-1.
- Buffers one sample per voice behind a valid/ready handshake from the voice oscillators.
- Applies note gate changes only at frame boundaries, so the downstream per-frame active-channel count is never corrupted mid-frame.

Parameters:
- NUM_VOICES, 4, voices per TDM frame; must equal 2**CHANBITS.
- D_W, 16, sample width (fix15 unsigned).
- CHANBITS, 2, channel index width.

Ports:
- dsp_clk  in  1  pipeline clock; all logic is on the rising edge.
- dsp_rst_n  in  1  asynchronous active-low reset.
- dsp_enable  in  1  slot advance enable.
- voice_sample_in  in  NUM_VOICES*D_W  flattened samples; voice i occupies bits [i*D_W +: D_W].
- voice_valid  in  NUM_VOICES  per-voice sample valid.
- voice_ready  out  NUM_VOICES  per-voice buffer can accept.
- gate_set  in  NUM_VOICES  note-on requests, single-cycle pulses.
- gate_clr  in  NUM_VOICES  note-off requests, single-cycle pulses.
- gate_mask  out  NUM_VOICES  currently applied gate mask.
- chan_out  out  CHANBITS  channel index to the pipeline.
- chan_en_out  out  1  channel carries a valid enabled sample.
- data_out  out  D_W  sample to the pipeline.
- frame_start  out  1  high on the cycle chan_out==0 is presented.

Behaviour:
- Reset, asynchronous:
  - slot counter = 0.
  - chan_out = 0, chan_en_out = 0, data_out = 0, frame_start = 0.
  - All buffers empty, so voice_ready = all ones.
  - gate_mask = 0; pending set/clear masks = 0.
  - Reset mid-frame discards buffered samples and pending gate requests.
- Slot counter: CHANBITS wide. Increments on each dsp_clk while dsp_enable=1. Wraps NUM_VOICES-1 -> 0.
- Output latency: outputs are registered one cycle after the slot counter value s:
  - chan_out <= s.
  - chan_en_out <= gate_mask_eff[s] & buf_full[s].
  - data_out <= buf_data[s] if chan_en_out is set, else the MID_POINT constant (16'h4000).
  - frame_start <= (s==0).
- dsp_enable=0: counter frozen; chan_en_out <= 0; chan_out, data_out and frame_start hold their values. Buffers still accept samples. The downstream summer is gated by the same dsp_enable.
- Per-voice 1-entry buffer:
  - voice_ready[i] = !buf_full[i] | consume[i].
  - Load when voice_valid[i] & voice_ready[i].
  - consume[i] = (s==i) & dsp_enable & gate_mask_eff[i] & buf_full[i].
  - Simultaneous load and consume: the buffer takes the new sample and stays full.
  - Data is accepted regardless of gate state.
- Underrun: slot i gated on but buffer empty. Result: chan_en_out=0, data_out=MID_POINT, and the slot still advances.
- Gate handling:
  - gate_set/gate_clr pulses accumulate into pend_set/pend_clr at any time. A set after a clear of the same bit overrides it, and vice versa; if both arrive in the same cycle, clear wins.
  - On the dsp_enable cycle where s==NUM_VOICES-1 (the wrap), gate_mask <= (gate_mask | pend_set) & ~pend_clr, and the pending masks are cleared. Pulses arriving that same cycle fold into the new mask.
  - gate_mask_eff is the gate_mask register. It is constant across a whole frame.
- Gated-off voice with a full buffer: the sample is held and not consumed until the voice is gated on.

Optional Feature:
- Macro: TDM_UNDERRUN_CTR_EN.
- Defined:
  - Adds output underrun_count [7:0]. Saturating at 8'hFF; increments once per underrun slot; reset to 0.
  - Adds input underrun_clr (1), which zeroes the count synchronously. If clear and increment occur together, the result is 0.
- Undefined: the port and counter are absent; functionality is otherwise identical.

Decomposition:
- Shared package tdm_pkg: D_W, CHANBITS, NUM_VOICES, MID_POINT (16'h4000), and the slot-index typedef.
- One sub-module, voice_sample_slot: the 1-entry buffer with load/consume/ready logic, instantiated NUM_VOICES times by generate.

Test Plan:
- Reset release, no gates set: chan_out cycles 0,1,2,3,0; chan_en_out always 0; data_out = 16'h4000; frame_start high on every 4th cycle.
- gate_set=4'b0101 pulsed mid-frame; voices 0 and 2 keep samples 16'h1000 and 16'h2000 valid: mask takes effect from the next frame only. Slots 0 and 2 then show en=1 with those data; slots 1 and 3 show en=0.
- Voice 1 gated on, valid low: underrun each frame with en=0 and data 16'h4000. With TDM_UNDERRUN_CTR_EN, the count reaches 8'hFF after 255 frames and holds.
- gate_set[3] and gate_clr[3] in the same cycle: bit 3 stays 0 after the wrap.
- Voice 0 valid asserted continuously with an incrementing sample: one sample consumed per frame; voice_ready[0] stays high on the consume cycle; no sample skipped or duplicated.
- dsp_enable dropped for 5 cycles at s==2, then dsp_rst_n asserted mid-frame: first the counter freezes with en=0 and resumes at slot 2. After reset, all outputs are 0, gate_mask=0 and voice_ready is all ones.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and slot type for the TDM voice scheduler.
package tdm_pkg;

  localparam int NUM_VOICES = 4;
  localparam int D_W        = 16;
  localparam int CHANBITS   = 2;

  localparam logic [D_W-1:0] MID_POINT = 16'h4000;

  typedef logic [CHANBITS-1:0] slot_t;

  function automatic slot_t next_slot(input slot_t s);
    return (s == slot_t'(NUM_VOICES - 1)) ? '0 : s + slot_t'(1);
  endfunction

endpackage

// File: rtl/voice_sample_slot.sv
// One-entry sample buffer for a single voice; a take and a load in the same cycle keep it full.
module voice_sample_slot
  import tdm_pkg::*;
#(
  parameter int W = D_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sample_in,
  input  logic         valid,
  output logic         ready,
  input  logic         take,
  output logic         full,
  output logic [W-1:0] data
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         consume;
  logic         load;

  always_comb begin
    consume = take & full_q;
    ready   = ~full_q | consume;
    load    = valid & ready;
    full_d  = full_q;
    data_d  = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = sample_in;
    end else if (consume) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/tdm_voice_scheduler.sv
// Round-robin TDM scheduler: one voice per dsp_clk slot, gate changes applied at frame wrap.
// Optional saturating underrun counter enabled by defining TDM_UNDERRUN_CTR_EN.
module tdm_voice_scheduler
  import tdm_pkg::*;
#(
  parameter int NUM_VOICES = tdm_pkg::NUM_VOICES,
  parameter int D_W        = tdm_pkg::D_W,
  parameter int CHANBITS   = tdm_pkg::CHANBITS
) (
  input  logic                      dsp_clk,
  input  logic                      dsp_rst_n,
  input  logic                      dsp_enable,
  input  logic [NUM_VOICES*D_W-1:0] voice_sample_in,
  input  logic [NUM_VOICES-1:0]     voice_valid,
  output logic [NUM_VOICES-1:0]     voice_ready,
  input  logic [NUM_VOICES-1:0]     gate_set,
  input  logic [NUM_VOICES-1:0]     gate_clr,
  output logic [NUM_VOICES-1:0]     gate_mask,
  output logic [CHANBITS-1:0]       chan_out,
  output logic                      chan_en_out,
  output logic [D_W-1:0]            data_out,
`ifdef TDM_UNDERRUN_CTR_EN
  input  logic                      underrun_clr,
  output logic [7:0]                underrun_count,
`endif
  output logic                      frame_start
);

  slot_t                  slot_q, slot_d;
  logic [CHANBITS-1:0]    chan_q, chan_d;
  logic                   en_q, en_d;
  logic [D_W-1:0]         data_q, data_d;
  logic                   fs_q, fs_d;

  logic [NUM_VOICES-1:0]  gate_mask_q, gate_mask_d;
  logic [NUM_VOICES-1:0]  pend_set_q, pend_set_d;
  logic [NUM_VOICES-1:0]  pend_clr_q, pend_clr_d;
  logic [NUM_VOICES-1:0]  set_acc, clr_acc;
  logic                   frame_wrap;

  logic [NUM_VOICES-1:0]  buf_take;
  logic [NUM_VOICES-1:0]  buf_full;
  logic [D_W-1:0]         buf_data [NUM_VOICES];

  // A voice is drained only on its own slot, and only while gated on.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      buf_take[i] = dsp_enable & (slot_q == slot_t'(i)) & gate_mask_q[i];
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_sample_slot #(
      .W(D_W)
    ) u_slot (
      .clk      (dsp_clk),
      .rst_n    (dsp_rst_n),
      .sample_in(voice_sample_in[g*D_W +: D_W]),
      .valid    (voice_valid[g]),
      .ready    (voice_ready[g]),
      .take     (buf_take[g]),
      .full     (buf_full[g]),
      .data     (buf_data[g])
    );
  end

  always_comb begin
    slot_d = slot_q;
    chan_d = chan_q;
    en_d   = 1'b0;
    data_d = data_q;
    fs_d   = fs_q;
    if (dsp_enable) begin
      slot_d = next_slot(slot_q);
      chan_d = slot_q;
      en_d   = gate_mask_q[slot_q] & buf_full[slot_q];
      data_d = en_d ? buf_data[slot_q] : MID_POINT;
      fs_d   = (slot_q == '0);
    end
  end

  // Newest request per bit wins; a set and clear landing together resolve to clear.
  always_comb begin
    set_acc     = (pend_set_q | gate_set) & ~gate_clr;
    clr_acc     = (pend_clr_q & ~gate_set) | gate_clr;
    frame_wrap  = dsp_enable & (slot_q == slot_t'(NUM_VOICES - 1));
    gate_mask_d = gate_mask_q;
    pend_set_d  = set_acc;
    pend_clr_d  = clr_acc;
    if (frame_wrap) begin
      gate_mask_d = (gate_mask_q | set_acc) & ~clr_acc;
      pend_set_d  = '0;
      pend_clr_d  = '0;
    end
  end

  always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
    if (!dsp_rst_n) begin
      slot_q      <= '0;
      chan_q      <= '0;
      en_q        <= 1'b0;
      data_q      <= '0;
      fs_q        <= 1'b0;
      gate_mask_q <= '0;
      pend_set_q  <= '0;
      pend_clr_q  <= '0;
    end else begin
      slot_q      <= slot_d;
      chan_q      <= chan_d;
      en_q        <= en_d;
      data_q      <= data_d;
      fs_q        <= fs_d;
      gate_mask_q <= gate_mask_d;
      pend_set_q  <= pend_set_d;
      pend_clr_q  <= pend_clr_d;
    end
  end

`ifdef TDM_UNDERRUN_CTR_EN
  logic [7:0] underrun_q, underrun_d;
  logic       underrun_evt;

  // Clear takes priority over a coincident underrun.
  always_comb begin
    underrun_evt = dsp_enable & gate_mask_q[slot_q] & ~buf_full[slot_q];
    underrun_d   = underrun_q;
    if (underrun_clr) begin
      underrun_d = '0;
    end else if (underrun_evt && (underrun_q != 8'hFF)) begin
      underrun_d = underrun_q + 8'd1;
    end
  end

  always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
    if (!dsp_rst_n) begin
      underrun_q <= '0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun_count = underrun_q;
`endif

  assign chan_out    = chan_q;
  assign chan_en_out = en_q;
  assign data_out    = data_q;
  assign frame_start = fs_q;
  assign gate_mask   = gate_mask_q;

endmodule
